// File: rtl/fifo_sync_param_if.sv
// Producer/consumer handshake bundle for fifo_sync_param.
// master = the surrounding logic, slave = the FIFO itself.
interface fifo_sync_param_if #(
    parameter int MEMORY_WIDTH = 8,
    parameter int ADDRESS_SIZE = 4
);
    logic                    w_en;
    logic [MEMORY_WIDTH-1:0] wdata;
    logic                    r_en;
    logic [MEMORY_WIDTH-1:0] rdata;
    logic                    w_full;
    logic                    r_empty;
    logic                    w_almost_full;
    logic                    r_almost_empty;
    logic [ADDRESS_SIZE:0]   count;
    logic                    overflow;
    logic                    underflow;

    modport master (
        output w_en, wdata, r_en,
        input  rdata, w_full, r_empty, w_almost_full, r_almost_empty,
        input  count, overflow, underflow
    );

    modport slave (
        input  w_en, wdata, r_en,
        output rdata, w_full, r_empty, w_almost_full, r_almost_empty,
        output count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with occupancy count, almost flags and error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads are registered.
module fifo_sync_param #(
    parameter int MEMORY_WIDTH     = 8,
    parameter int MEMORY_DEPTH     = 16,
    parameter int ADDRESS_SIZE     = 4,
    parameter int ALMOST_FULL_LVL  = 12,
    parameter int ALMOST_EMPTY_LVL = 4
) (
    input logic              clk,
    input logic              rst,
    fifo_sync_param_if.slave bus
);

    localparam logic [ADDRESS_SIZE:0] DEPTH_C = (ADDRESS_SIZE+1)'(MEMORY_DEPTH);
    localparam logic [ADDRESS_SIZE:0] AF_LVL_C = (ADDRESS_SIZE+1)'(ALMOST_FULL_LVL);
    localparam logic [ADDRESS_SIZE:0] AE_LVL_C = (ADDRESS_SIZE+1)'(ALMOST_EMPTY_LVL);

    logic [MEMORY_WIDTH-1:0] mem_q [MEMORY_DEPTH];

    logic [ADDRESS_SIZE-1:0] wptr_q, wptr_d;
    logic [ADDRESS_SIZE-1:0] rptr_q, rptr_d;
    logic [ADDRESS_SIZE:0]   count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic                    underflow_q, underflow_d;

    logic full, empty;
    logic wr_ok, rd_ok;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // A full FIFO still pops and an empty FIFO still pushes; only the blocked side is rejected.
    assign wr_ok = bus.w_en && !full;
    assign rd_ok = bus.r_en && !empty;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = bus.w_en && full;
        underflow_d = bus.r_en && empty;

        if (wr_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_ok) begin
            rptr_d = rptr_q + 1'b1;
        end

        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; pointers guarantee stale words are never exposed.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wptr_q] <= bus.wdata;
        end
    end

`ifdef FIFO_FWFT_EN
    assign bus.rdata = empty ? '0 : mem_q[rptr_q];
`else
    logic [MEMORY_WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (rd_ok) begin
            rdata_d = mem_q[rptr_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign bus.rdata = rdata_q;
`endif

    assign bus.count          = count_q;
    assign bus.w_full         = full;
    assign bus.r_empty        = empty;
    assign bus.w_almost_full  = (count_q >= AF_LVL_C);
    assign bus.r_almost_empty = (count_q <= AE_LVL_C);
    assign bus.overflow       = overflow_q;
    assign bus.underflow      = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed plus randomized bench for fifo_sync_param against a queue-based reference model.
module tb_fifo_sync_param;

    localparam int W     = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int AF    = 12;
    localparam int AE    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_sync_param_if #(.MEMORY_WIDTH(W), .ADDRESS_SIZE(AW)) bus ();

    fifo_sync_param #(
        .MEMORY_WIDTH(W), .MEMORY_DEPTH(DEPTH), .ADDRESS_SIZE(AW),
        .ALMOST_FULL_LVL(AF), .ALMOST_EMPTY_LVL(AE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [W-1:0] q[$];
    logic [W-1:0] exp_rd_reg;
    logic         exp_ov;
    logic         exp_un;

    int    passed = 0;
    int    total  = 0;
    string phase  = "init";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    endtask

    task automatic model_reset();
        q.delete();
        exp_rd_reg = '0;
        exp_ov     = 1'b0;
        exp_un     = 1'b0;
    endtask

    task automatic check_all();
        int n;
        logic [W-1:0] exp_rd;
        n = q.size();
`ifdef FIFO_FWFT_EN
        exp_rd = (n != 0) ? q[0] : '0;
`else
        exp_rd = exp_rd_reg;
`endif
        chk("count",  32'(bus.count),          n);
        chk("empty",  32'(bus.r_empty),        32'(n == 0));
        chk("full",   32'(bus.w_full),         32'(n == DEPTH));
        chk("afull",  32'(bus.w_almost_full),  32'(n >= AF));
        chk("aempty", 32'(bus.r_almost_empty), 32'(n <= AE));
        chk("ovf",    32'(bus.overflow),       32'(exp_ov));
        chk("unf",    32'(bus.underflow),      32'(exp_un));
        chk("rdata",  32'(bus.rdata),          32'(exp_rd));
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic cyc(input logic we, input logic re, input logic [W-1:0] wd);
        logic was_full, was_empty;
        bus.w_en  = we;
        bus.r_en  = re;
        bus.wdata = wd;
        @(posedge clk);
        #1;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        exp_ov = we && was_full;
        exp_un = re && was_empty;
        if (re && !was_empty) exp_rd_reg = q.pop_front();
        if (we && !was_full) q.push_back(wd);
        check_all();
    endtask

    // Asynchronous reset raised between edges; outputs must clear before any clock.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        bus.w_en = 1'b0;
        bus.r_en = 1'b0;
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        bus.w_en  = 1'b0;
        bus.r_en  = 1'b0;
        bus.wdata = '0;
        model_reset();

        phase = "reset";
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        phase = "fill";
        for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, W'(i));

        phase = "overflow";
        cyc(1'b1, 1'b0, 8'hAA);
        cyc(1'b1, 1'b0, 8'hAA);
        cyc(1'b0, 1'b0, 8'h00);

        phase = "drain";
        for (int i = 1; i <= 16; i++) cyc(1'b0, 1'b1, 8'h00);
        phase = "underflow";
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);

        phase = "wrap";
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, W'(8'h20 + i));
        for (int i = 3; i < 43; i++) cyc(1'b1, 1'b1, W'(8'h20 + i));

        phase = "full_rw";
        while (q.size() < DEPTH) cyc(1'b1, 1'b0, W'($urandom_range(0, 255)));
        cyc(1'b1, 1'b1, 8'h55);

        phase = "empty_rw";
        while (q.size() > 0) cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b1, 8'h66);
        cyc(1'b0, 1'b1, 8'h00);

        phase = "async_rst";
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, W'(8'h70 + i));
        async_reset();
        cyc(1'b0, 1'b1, 8'h00);

        phase = "random";
        for (int i = 0; i < 600; i++) begin
            int wp, rp;
            unique case ((i / 60) % 3)
                0:       begin wp = 75; rp = 30; end
                1:       begin wp = 30; rp = 75; end
                default: begin wp = 50; rp = 50; end
            endcase
            if (i == 300) async_reset();
            cyc(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp),
                W'($urandom_range(0, 255)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
